miriscv_lsu: RTL and testbench

Load/store unit sitting between the core's execute stage and `miriscv_addr_decoder`. It is the initiator side of the device bus: it turns a core memory operation (lb/lh/lw/lbu/lhu/sb/sh/sw) into one request on the bus, with a word-aligned address, byte mask and lane-replicated write data. For loads it captures the read word, extracts and extends the addressed byte or half, and stalls the core until the result is ready. Misaligned and illegal-size accesses never reach the bus; they are reported to the core instead.

---
 rtl/miriscv_lsu_pkg.sv | 45 ++++
 rtl/miriscv_lsu_extend.sv | 26 ++
 rtl/miriscv_lsu.sv | 145 ++++++++++++++
 tb/tb_miriscv_lsu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_lsu_pkg.sv
// Shared encodings and request-decode helpers for the load/store unit.
package miriscv_lsu_pkg;

    typedef enum logic [2:0] {
        LDST_B  = 3'b000,
        LDST_H  = 3'b001,
        LDST_W  = 3'b010,
        LDST_BU = 3'b100,
        LDST_HU = 3'b101
    } ldst_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } lsu_state_e;

    // Misaligned halves/words and the three unused funct3 codes never reach the bus.
    function automatic logic access_bad(logic [2:0] size, logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: return 1'b0;
            LDST_H, LDST_HU: return off[0];
            LDST_W:          return off != 2'b00;
            default:         return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(logic [1:0] sz, logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(logic [1:0] sz, logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/miriscv_lsu_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module miriscv_lsu_extend
    import miriscv_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: data_o = {24'h000000, byte_sel};
            LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: data_o = {16'h0000, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: turns one core memory operation into a single registered bus request.
module miriscv_lsu
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_o,
    output logic        lsu_misalign_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        misalign_q, misalign_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        breq_q, breq_d;
    logic        bwe_q, bwe_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ext_rdata;

    miriscv_lsu_extend u_extend (
        .rdata_i  (data_rdata_i),
        .offset_i (off_q),
        .size_i   (size_q),
        .data_o   (ext_rdata)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        off_d      = off_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        breq_d     = 1'b0;
        bwe_d      = 1'b0;
        be_d       = be_q;
        baddr_d    = baddr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    we_d   = lsu_we_i;
                    size_d = lsu_size_i;
                    off_d  = lsu_addr_i[1:0];
                    if (access_bad(lsu_size_i, lsu_addr_i[1:0])) begin
                        misalign_d = 1'b1;
                        result_d   = '0;
                        state_d    = DONE;
                    end else begin
                        // Bus fields are registered here so they appear exactly in ACCESS.
                        breq_d  = 1'b1;
                        bwe_d   = lsu_we_i;
                        be_d    = lane_mask(lsu_size_i[1:0], lsu_addr_i[1:0]);
                        baddr_d = {lsu_addr_i[31:2], 2'b00};
                        wdata_d = lane_wdata(lsu_size_i[1:0], lsu_data_i);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    result_d = ext_rdata;
                    state_d  = DONE;
                end
            end
            default: begin
                misalign_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            breq_q     <= 1'b0;
            bwe_q      <= 1'b0;
            be_q       <= '0;
            baddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            off_q      <= off_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            breq_q     <= breq_d;
            bwe_q      <= bwe_d;
            be_q       <= be_d;
            baddr_q    <= baddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign lsu_stall_o    = lsu_req_i && (state_q != DONE);
    assign lsu_data_o     = result_q;
    assign lsu_misalign_o = misalign_q;
    assign data_req_o     = breq_q;
    assign data_we_o      = bwe_q;
    assign data_be_o      = be_q;
    assign data_addr_o    = baddr_q;
    assign data_wdata_o   = wdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu at READ_LATENCY 1 and 3.
module tb_miriscv_lsu;

    localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req = 1'b0;
    logic        sel3 = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_size = 3'b000;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_data = '0;
    logic [31:0] rdata = JUNK;

    logic        req1, req3;
    logic [31:0] data1, data3, addr1, addr3, wdata1, wdata3;
    logic        stall1, stall3, mis1, mis3, breq1, breq3, bwe1, bwe3;
    logic [3:0]  be1, be3;

    logic [31:0] s_data, s_addr, s_wdata;
    logic        s_stall, s_mis, s_req, s_we;
    logic [3:0]  s_be;

    int checks = 0;
    int errors = 0;

    assign req1 = lsu_req && !sel3;
    assign req3 = lsu_req && sel3;

    assign s_data  = sel3 ? data3  : data1;
    assign s_addr  = sel3 ? addr3  : addr1;
    assign s_wdata = sel3 ? wdata3 : wdata1;
    assign s_stall = sel3 ? stall3 : stall1;
    assign s_mis   = sel3 ? mis3   : mis1;
    assign s_req   = sel3 ? breq3  : breq1;
    assign s_we    = sel3 ? bwe3   : bwe1;
    assign s_be    = sel3 ? be3    : be1;

    miriscv_lsu #(.READ_LATENCY(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .lsu_req_i(req1), .lsu_we_i(lsu_we),
        .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .lsu_data_o(data1), .lsu_stall_o(stall1), .lsu_misalign_o(mis1),
        .data_req_o(breq1), .data_we_o(bwe1), .data_be_o(be1),
        .data_addr_o(addr1), .data_wdata_o(wdata1), .data_rdata_i(rdata)
    );

    miriscv_lsu #(.READ_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .lsu_req_i(req3), .lsu_we_i(lsu_we),
        .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .lsu_data_o(data3), .lsu_stall_o(stall3), .lsu_misalign_o(mis3),
        .data_req_o(breq3), .data_we_o(bwe3), .data_be_o(be3),
        .data_addr_o(addr3), .data_wdata_o(wdata3), .data_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          l3;
        bit          we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] wdata;
        logic [31:0] result;
        bit          mis;
        int          stalls;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int  stalls = 0;
        int  pulses = 0;
        int  k = -1;
        int  lat;
        bit  done = 1'b0;
        lat = v.l3 ? 3 : 1;
        @(negedge clk);
        sel3 = v.l3;
        #1;
        chk($sformatf("v%0d idle_misalign", idx), {31'b0, s_mis}, 32'h0);
        lsu_we   = v.we;
        lsu_size = v.size;
        lsu_addr = v.addr;
        lsu_data = v.data;
        lsu_req  = 1'b1;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            #1;
            if (k >= 0) k++;
            if (s_req) begin
                pulses++;
                k = 0;
                chk($sformatf("v%0d be", idx), {28'b0, s_be}, {28'b0, v.be});
                chk($sformatf("v%0d addr", idx), s_addr, v.baddr);
                chk($sformatf("v%0d wdata", idx), s_wdata, v.wdata);
                chk($sformatf("v%0d we", idx), {31'b0, s_we}, {31'b0, v.we});
            end
            rdata = (k == lat) ? v.rd : JUNK;
            if (s_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                chk($sformatf("v%0d result", idx), s_data, v.result);
                chk($sformatf("v%0d misalign", idx), {31'b0, s_mis}, {31'b0, v.mis});
                chk($sformatf("v%0d stalls", idx), stalls, v.stalls);
                chk($sformatf("v%0d bus_pulses", idx), pulses, v.mis ? 0 : 1);
                lsu_req = 1'b0;
                rdata   = JUNK;
            end
            if (!done) @(negedge clk);
        end
        if (!done) begin
            chk($sformatf("v%0d timeout", idx), 32'h1, 32'h0);
            lsu_req = 1'b0;
        end
    endtask

    initial begin
        bit seen;
        //          l3 we size    addr          data          rdata         be       baddr         wdata         result        mis st
        vecs[0]  = '{0, 0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0, 3};
        vecs[1]  = '{0, 0, 3'b010, 32'h0000_0006, 32'h0,        32'h1111_1111, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 1};
        vecs[2]  = '{0, 0, 3'b000, 32'h0000_0013, 32'h0,        32'h80FF_0000, 4'b1000, 32'h0000_0010, 32'h0,        32'hFFFF_FF80, 0, 3};
        vecs[3]  = '{0, 0, 3'b011, 32'h0000_0008, 32'h0,        32'h2222_2222, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 1};
        vecs[4]  = '{0, 0, 3'b100, 32'h0000_0013, 32'h0,        32'h80FF_0000, 4'b1000, 32'h0000_0010, 32'h0,        32'h0000_0080, 0, 3};
        vecs[5]  = '{0, 1, 3'b001, 32'h0000_0082, 32'h1234_ABCD, 32'h0,        4'b1100, 32'h0000_0080, 32'hABCD_ABCD, 32'h0,         0, 2};
        vecs[6]  = '{0, 0, 3'b001, 32'h0000_0022, 32'h0,        32'h8001_7FFF, 4'b1100, 32'h0000_0020, 32'h0,        32'hFFFF_8001, 0, 3};
        vecs[7]  = '{0, 1, 3'b000, 32'h0000_0041, 32'hFFFF_FFA5, 32'h0,        4'b0010, 32'h0000_0040, 32'hA5A5_A5A5, 32'h0,         0, 2};
        vecs[8]  = '{0, 0, 3'b000, 32'h0000_0011, 32'h0,        32'h0000_7F00, 4'b0010, 32'h0000_0010, 32'h0,        32'h0000_007F, 0, 3};
        vecs[9]  = '{0, 1, 3'b001, 32'h0000_0035, 32'h0000_BEEF, 32'h0,        4'b0000, 32'h0,         32'h0,        32'h0,         1, 1};
        vecs[10] = '{0, 1, 3'b010, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,        4'b1111, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,         0, 2};
        vecs[11] = '{0, 0, 3'b101, 32'h0000_0003, 32'h0,        32'h3333_3333, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 1};
        vecs[12] = '{0, 1, 3'b110, 32'h0000_0040, 32'h1234_5678, 32'h0,        4'b0000, 32'h0,         32'h0,        32'h0,         1, 1};
        vecs[13] = '{1, 0, 3'b101, 32'h0000_0020, 32'h0,        32'hAAAA_8001, 4'b0011, 32'h0000_0020, 32'h0,        32'h0000_8001, 0, 5};
        vecs[14] = '{1, 0, 3'b010, 32'h0000_002C, 32'h0,        32'h0F1E_2D3C, 4'b1111, 32'h0000_002C, 32'h0,        32'h0F1E_2D3C, 0, 5};

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst data_o", data1, 32'h0);
        chk("rst misalign", {31'b0, mis1}, 32'h0);
        chk("rst stall", {31'b0, stall1}, 32'h0);
        chk("rst req", {31'b0, breq1}, 32'h0);
        chk("rst we", {31'b0, bwe1}, 32'h0);
        chk("rst be", {28'b0, be1}, 32'h0);
        chk("rst addr", addr1, 32'h0);
        chk("rst wdata", wdata1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_op(i, vecs[i]);

        // Request withdrawn after acceptance: the load still completes.
        @(negedge clk);
        sel3 = 1'b0;
        lsu_we = 1'b0; lsu_size = 3'b100; lsu_addr = 32'h0000_0012; lsu_data = '0;
        lsu_req = 1'b1;
        @(negedge clk);
        #1;
        chk("drop access_req", {31'b0, s_req}, 32'h1);
        lsu_req = 1'b0;
        #1;
        chk("drop stall_low", {31'b0, s_stall}, 32'h0);
        @(negedge clk);
        rdata = 32'h00C3_0000;
        @(negedge clk);
        #1;
        rdata = JUNK;
        chk("drop result", s_data, 32'h0000_00C3);
        chk("drop req_idle", {31'b0, s_req}, 32'h0);

        // Reset asserted while the latency-3 unit waits for read data.
        @(negedge clk);
        sel3 = 1'b1;
        lsu_we = 1'b0; lsu_size = 3'b010; lsu_addr = 32'h0000_0044; lsu_data = '0;
        lsu_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = s_req;
        end
        chk("rstmid access_seen", {31'b0, seen}, 32'h1);
        @(negedge clk);
        #1;
        chk("rstmid stall_wait", {31'b0, s_stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstmid data_o", data3, 32'h0);
        chk("rstmid misalign", {31'b0, mis3}, 32'h0);
        chk("rstmid req", {31'b0, breq3}, 32'h0);
        chk("rstmid we", {31'b0, bwe3}, 32'h0);
        chk("rstmid be", {28'b0, be3}, 32'h0);
        chk("rstmid addr", addr3, 32'h0);
        chk("rstmid wdata", wdata3, 32'h0);
        chk("rstmid stall_idle_req", {31'b0, stall3}, 32'h1);
        lsu_req = 1'b0;
        #1;
        chk("rstmid stall_noreq", {31'b0, stall3}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        vecs[0] = '{1, 0, 3'b000, 32'h0000_0049, 32'h0, 32'h0000_9C00, 4'b0010, 32'h0000_0048, 32'h0, 32'hFFFF_FF9C, 0, 5};
        run_op(15, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
